// File: rtl/wl_plane_sched_if.sv
// wl_plane_sched_if: control, bitmap and DAC/CIM handshake bundle for the word-line plane scheduler
interface wl_plane_sched_if #(
    parameter int NUM_INPUTS = 64,
    parameter int PLANE_BITS = 8
);
    logic                               start;
    logic                               abort;
    logic [NUM_INPUTS*PLANE_BITS-1:0]   in_vec;
    logic [NUM_INPUTS-1:0]              wl_bitmap;
    logic                               wl_valid_pulse;
    logic                               dac_done_pulse;
    logic                               cim_start_pulse;
    logic                               cim_done_pulse;
    logic [3:0]                         plane_idx;
    logic                               busy;
    logic                               done_pulse;
    logic                               err_timeout;
    modport master (
        output start, abort, in_vec, dac_done_pulse, cim_done_pulse,
        input  wl_bitmap, wl_valid_pulse, cim_start_pulse, plane_idx, busy, done_pulse, err_timeout
    );
    modport slave (
        input  start, abort, in_vec, dac_done_pulse, cim_done_pulse,
        output wl_bitmap, wl_valid_pulse, cim_start_pulse, plane_idx, busy, done_pulse, err_timeout
    );
endinterface

// File: rtl/wl_plane_sched.sv
// wl_plane_sched: issues bit-planes MSB-first to DAC then CIM with watchdog; WL_SCHED_SKIP_ZERO_EN skips all-zero planes
module wl_plane_sched #(
    parameter int NUM_INPUTS     = 64,
    parameter int PLANE_BITS     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic             clk,
    input logic             rst,
    wl_plane_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DAC, WAIT_CIM, DONE} state_t;
    state_t                           state_q, state_d;
    logic [NUM_INPUTS*PLANE_BITS-1:0] vec_q, vec_d;
    logic [NUM_INPUTS-1:0]            bitmap_q, bitmap_d, plane_bits;
    logic [PLANE_BITS-1:0]            plane_sel;
    logic [3:0]                       idx_q, idx_d;
    logic [15:0]                      wd_q, wd_d;
    logic                             wl_valid_q, wl_valid_d, cim_start_q, cim_start_d;
    logic                             done_q, done_d, err_q, err_d, wd_hit;
    assign plane_sel = PLANE_BITS'(1) << idx_q;
    assign wd_hit    = wd_q == 16'(TIMEOUT_CYCLES - 1);
    always_comb begin
        plane_bits = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            plane_bits[i] = |(vec_q[i*PLANE_BITS +: PLANE_BITS] & plane_sel);
    end
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        bitmap_d    = bitmap_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        err_d       = err_q;
        wl_valid_d  = 1'b0;
        cim_start_d = 1'b0;
        done_d      = 1'b0;
        // abort outranks any done input seen in the same cycle
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    vec_d   = bus.in_vec;
                    idx_d   = 4'(PLANE_BITS - 1);
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
                ISSUE: begin
                    bitmap_d = plane_bits;
`ifdef WL_SCHED_SKIP_ZERO_EN
                    if (plane_bits == '0) begin
                        state_d = idx_q == 4'd0 ? DONE : ISSUE;
                        idx_d   = idx_q == 4'd0 ? idx_q : idx_q - 4'd1;
                    end else begin
                        wl_valid_d = 1'b1;
                        wd_d       = '0;
                        state_d    = WAIT_DAC;
                    end
`else
                    wl_valid_d = 1'b1;
                    wd_d       = '0;
                    state_d    = WAIT_DAC;
`endif
                end
                WAIT_DAC: if (bus.dac_done_pulse) begin
                    cim_start_d = 1'b1;
                    wd_d        = '0;
                    state_d     = WAIT_CIM;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
                WAIT_CIM: if (bus.cim_done_pulse) begin
                    state_d = idx_q == 4'd0 ? DONE : ISSUE;
                    idx_d   = idx_q == 4'd0 ? idx_q : idx_q - 4'd1;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            bitmap_q    <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            wl_valid_q  <= 1'b0;
            cim_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            bitmap_q    <= bitmap_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            wl_valid_q  <= wl_valid_d;
            cim_start_q <= cim_start_d;
            done_q      <= done_d;
        end
    end
    assign bus.wl_bitmap       = bitmap_q;
    assign bus.wl_valid_pulse  = wl_valid_q;
    assign bus.cim_start_pulse = cim_start_q;
    assign bus.plane_idx       = idx_q;
    assign bus.busy            = state_q != IDLE;
    assign bus.done_pulse      = done_q;
    assign bus.err_timeout     = err_q;
endmodule

// File: tb/tb_wl_plane_sched.sv
// tb_wl_plane_sched: randomized scoreboard bench; expected plane bitmaps are queued at start and popped on each wl_valid_pulse
module tb_wl_plane_sched;
    localparam int NI = 16;
    localparam int PB = 8;
    localparam int W  = NI * PB;
    typedef struct {
        logic [NI-1:0] bm;
        logic [3:0]    idx;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_abort = 1'b0, m_cim = 1'b0;
    logic r_abort = 1'b0, r_cim = 1'b0, r_dac = 1'b0;
    int   n_checks = 0, n_err = 0;
    int   n_wl = 0, n_cim = 0, n_done = 0, cyc = 0, last_cim = -100, last_dac = -100;
    int   exp_wl = 0, wl0 = 0, done0 = 0;
    int   dac_cnt = 0, cim_cnt = 0, dac_dly = 3, cim_dly = 5, abort_plane = -1;
    logic dac_en = 1'b1, cim_en = 1'b1;
    logic prev_wl = 1'b0, prev_cs = 1'b0, prev_done = 1'b0;
    exp_t exp_q[$];
    wl_plane_sched_if #(.NUM_INPUTS(NI), .PLANE_BITS(PB)) bus ();
    wl_plane_sched #(.NUM_INPUTS(NI), .PLANE_BITS(PB), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    assign bus.abort          = m_abort | r_abort;
    assign bus.cim_done_pulse = m_cim | r_cim;
    assign bus.dac_done_pulse = r_dac;
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    // reference: plane p bitmap bit i is bit p of input i, planes issued MSB first
    task automatic push_planes(input logic [W-1:0] v, input int lo);
        exp_t e;
        exp_wl = 0;
        for (int p = PB - 1; p >= lo; p--) begin
            for (int i = 0; i < NI; i++) e.bm[i] = v[i*PB + p];
            e.idx = 4'(p);
`ifdef WL_SCHED_SKIP_ZERO_EN
            if (e.bm == '0) continue;
`endif
            exp_q.push_back(e);
            exp_wl++;
        end
    endtask
    task automatic start_vec(input logic [W-1:0] v, input int lo);
        push_planes(v, lo);
        wl0        = n_wl;
        done0      = n_done;
        bus.in_vec = v;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask
    task automatic wait_idle();
        for (int k = 0; k < 1000 && bus.busy; k++) begin
            @(posedge clk); #1;
        end
        check("idle_reached", 64'(bus.busy), 0);
        @(negedge clk); #1;
    endtask
    task automatic end_vec(input int exp_done);
        check("done_count", 64'(n_done - done0), 64'(exp_done));
        check("wl_count", 64'(n_wl - wl0), 64'(exp_wl));
        check("queue_left", 64'(exp_q.size()), 0);
    endtask
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction
    // DAC/CIM stage model: answers each trigger after a programmable delay
    initial forever begin
        @(posedge clk); #1;
        r_dac = 1'b0; r_cim = 1'b0; r_abort = 1'b0;
        if (rst) begin
            dac_cnt = 0; cim_cnt = 0;
        end else begin
            if (dac_cnt == 1) r_dac = 1'b1;
            if (dac_cnt > 0) dac_cnt--;
            if (cim_cnt == 1) begin
                r_cim = 1'b1;
                if (int'(bus.plane_idx) == abort_plane) r_abort = 1'b1;
            end
            if (cim_cnt > 0) cim_cnt--;
            if (bus.wl_valid_pulse && dac_en) dac_cnt = dac_dly;
            if (bus.cim_start_pulse && cim_en) cim_cnt = cim_dly;
        end
    end
    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.dac_done_pulse) last_dac = cyc;
        if (bus.cim_done_pulse) last_cim = cyc;
        if (bus.wl_valid_pulse) begin
            n_wl++;
            check("wl_gap", 64'(prev_wl), 0);
            check("wl_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("wl_bitmap", 64'(bus.wl_bitmap), 64'(e.bm));
                check("plane_idx", 64'(bus.plane_idx), 64'(e.idx));
            end
        end
        if (bus.cim_start_pulse) begin
            n_cim++;
            check("cim_gap", 64'(prev_cs), 0);
            check("cim_lat", 64'(cyc - last_dac), 1);
        end
        if (bus.done_pulse) begin
            n_done++;
            check("done_gap", 64'(prev_done), 0);
            check("done_lat", 64'(cyc - last_cim), 2);
        end
        prev_wl   = bus.wl_valid_pulse;
        prev_cs   = bus.cim_start_pulse;
        prev_done = bus.done_pulse;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "bench timeout");
    end
    initial begin
        logic [W-1:0] v;
        int           k;
        bus.start  = 1'b0;
        bus.in_vec = '0;
        cycles(3);
        check("rst_bitmap", 64'(bus.wl_bitmap), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_idx", 64'(bus.plane_idx), 0);
        check("rst_err", 64'(bus.err_timeout), 0);
        check("rst_pulses", 64'({bus.wl_valid_pulse, bus.cim_start_pulse, bus.done_pulse}), 0);
        rst = 1'b0;
        cycles(2);
        // single MSB set on input 0: only plane 7 carries a word line
        v = '0;
        v[7:0] = 8'h80;
        start_vec(v, 0);
        check("lat_busy", 64'(bus.busy), 1);
        check("lat_wl_early", 64'(bus.wl_valid_pulse), 0);
        @(posedge clk); #1;
        check("lat_wl", 64'(bus.wl_valid_pulse), 1);
        wait_idle();
        end_vec(1);
        for (int r = 0; r < 6; r++) begin
            dac_dly = $urandom_range(1, 8);
            cim_dly = $urandom_range(1, 8);
            v = r == 0 ? '0 : r == 1 ? '1 : rand_vec();
            start_vec(v, 0);
            wait_idle();
            end_vec(1);
        end
        // watchdog: DAC never answers
        dac_en = 1'b0;
        start_vec('1, 7);
        cycles(16);
        check("to_err_early", 64'(bus.err_timeout), 0);
        check("to_busy_early", 64'(bus.busy), 1);
        cycles(1);
        check("to_err", 64'(bus.err_timeout), 1);
        check("to_busy", 64'(bus.busy), 0);
        cycles(5);
        end_vec(0);
        dac_en = 1'b1;
        start_vec(rand_vec(), 0);
        check("to_err_clear", 64'(bus.err_timeout), 0);
        wait_idle();
        end_vec(1);
        // abort coinciding with cim_done at plane 3
        dac_dly = 3; cim_dly = 5; abort_plane = 3;
        start_vec('1, 3);
        for (k = 0; k < 2000 && !bus.abort; k++) @(negedge clk);
        check("abort_seen", 64'(bus.abort), 1);
        @(posedge clk); #1;
        check("abort_busy", 64'(bus.busy), 0);
        abort_plane = -1;
        cycles(20);
        end_vec(0);
        // stray cim_done and re-start while waiting on the DAC
        dac_dly = 6;
        v = rand_vec();
        v[PB-1] = 1'b1;
        start_vec(v, 0);
        @(posedge clk); #1;
        bus.start = 1'b1; m_cim = 1'b1; bus.in_vec = ~v;
        @(posedge clk); #1;
        bus.start = 1'b0; m_cim = 1'b0;
        wait_idle();
        end_vec(1);
        // reset in WAIT_CIM at plane 5
        dac_dly = 2; cim_dly = 8;
        start_vec('1, 5);
        for (k = 0; k < 2000 && !(bus.cim_start_pulse && bus.plane_idx == 4'd5); k++) @(negedge clk);
        check("rst_point", 64'(bus.plane_idx), 5);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_outs", 64'({bus.wl_bitmap, bus.wl_valid_pulse, bus.cim_start_pulse,
                                    bus.done_pulse, bus.busy, bus.err_timeout, bus.plane_idx}), 0);
        cycles(2);
        rst = 1'b0;
        cycles(20);
        end_vec(0);
        cim_dly = 5;
        start_vec(rand_vec(), 0);
        wait_idle();
        end_vec(1);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/wl_plane_sched.md
WL_PLANE_SCHED -- requirements
Module: wl_plane_sched

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 64, number of word lines per bit-plane.
REQ-002 SHALL have parameter PLANE_BITS, default 8, number of bit-planes per input vector (1..16).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit per wait state (1..65535).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  1-cycle request to begin one vector.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current vector.
REQ-008 SHALL have port in_vec  input  NUM_INPUTS*PLANE_BITS  input values; input i occupies bits [i*PLANE_BITS +: PLANE_BITS].
REQ-009 SHALL have port wl_bitmap  output  NUM_INPUTS  registered bit-plane bitmap to the DAC stage.
REQ-010 SHALL have port wl_valid_pulse  output  1  1-cycle DAC trigger.
REQ-011 SHALL have port dac_done_pulse  input  1  DAC settled.
REQ-012 SHALL have port cim_start_pulse  output  1  1-cycle CIM compute trigger.
REQ-013 SHALL have port cim_done_pulse  input  1  CIM and readout finished for the current plane.
REQ-014 SHALL have port plane_idx  output  4  index of the plane in flight.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port done_pulse  output  1  1-cycle vector-complete pulse.
REQ-017 SHALL have port err_timeout  output  1  sticky watchdog flag.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, WAIT_DAC, WAIT_CIM and DONE.
REQ-019 IDLE: start=1 SHALL latch in_vec into an internal register, set plane_idx=PLANE_BITS-1, clear err_timeout and go to ISSUE; start SHALL be ignored in every other state.
REQ-020 ISSUE: SHALL register wl_bitmap[i]=latched_vec[i*PLANE_BITS+plane_idx] and pulse wl_valid_pulse in the same cycle, then go to WAIT_DAC; wl_bitmap SHALL hold until the next ISSUE.
REQ-021 WAIT_DAC: dac_done_pulse SHALL cause cim_start_pulse=1 in the next cycle and a move to WAIT_CIM.
REQ-022 WAIT_CIM: cim_done_pulse with plane_idx>0 SHALL decrement plane_idx and go to ISSUE; with plane_idx==0 it SHALL go to DONE.
REQ-023 DONE: SHALL assert done_pulse for exactly 1 cycle and return to IDLE.
REQ-024 Minimum latency: start at T gives wl_valid_pulse at T+2; done_pulse follows the last cim_done_pulse by 2 cycles.
REQ-025 A dac_done_pulse or cim_done_pulse arriving outside its wait state SHALL be ignored.
REQ-026 The watchdog counter SHALL clear on entry to WAIT_DAC or WAIT_CIM and increment each cycle there; reaching TIMEOUT_CYCLES SHALL set err_timeout and return to IDLE with no done_pulse.
REQ-027 abort=1 in any non-IDLE state SHALL return to IDLE in the next cycle with no done_pulse; abort SHALL take priority over every done input arriving in the same cycle.
REQ-028 Pulse outputs SHALL never be high for 2 consecutive cycles.

Reset
REQ-029 rst=1 SHALL force state=IDLE; wl_bitmap, latched vector, plane_idx, watchdog, all pulses, busy and err_timeout to 0.
REQ-030 Reset mid-vector SHALL discard the vector silently, with no done_pulse after release.

Configuration
REQ-031 The macro WL_SCHED_SKIP_ZERO_EN SHALL control zero-plane skipping.
- Defined: in ISSUE, an all-zero bitmap SHALL skip wl_valid_pulse, the DAC wait and the CIM wait. It SHALL then decrement plane_idx and go to ISSUE, or go to DONE if plane_idx==0. wl_bitmap SHALL still update.
- Undefined: every plane SHALL be issued regardless of content.

Verification
REQ-032 in_vec input0=0x80, all others 0, with dac_done 3 cycles and cim_done 5 cycles after each trigger -> 8 planes; plane 7 wl_bitmap=bit0 set, planes 6..0 all zero; one done_pulse.
REQ-033 Same stimulus with WL_SCHED_SKIP_ZERO_EN defined -> exactly 1 wl_valid_pulse and 1 cim_start_pulse, then done_pulse.
REQ-034 TIMEOUT_CYCLES=16 and dac_done never returned -> err_timeout=1 16 cycles after entering WAIT_DAC, back to IDLE, no done_pulse; the next start clears err_timeout.
REQ-035 abort asserted in the same cycle as cim_done_pulse at plane 3 -> IDLE next cycle, busy=0, no further wl_valid_pulse, no done_pulse.
REQ-036 start re-pulsed while busy and a stray cim_done_pulse in WAIT_DAC -> both ignored; sequence completes unchanged.
REQ-037 rst asserted in WAIT_CIM at plane 5 -> all outputs 0 immediately; after release, no done_pulse and a new start runs normally.
